// File: rtl/k16_cpu.sv
// k16_cpu: multi-cycle 16-bit word-addressed CPU with a single shared
// synchronous memory port (read data valid one cycle after the address).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high; aborts the current instruction
//   hold     - sticky halt flag, set by a taken jump/branch to itself
//   busy     - high in every state except FETCH
//   address  - memory address, combinational from the current state
//   data_in  - memory read data for the address of the previous cycle
//   data_out - store data, 0 whenever write is low
//   write    - one-cycle write strobe, captured by memory on the same edge
//
// Registers r0..r6 live in gpr_r; r6 doubles as the stack pointer and r7
// is the PC (pc_r). The PC is incremented in FETCH, so any read of r7 during
// EXEC sees the address of the instruction plus one.
module k16_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        hold,
    output logic        busy,
    output logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        write
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_STACK = 3'b001;
    localparam logic [2:0] OP_BR    = 3'b010;
    localparam logic [2:0] OP_LDI   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_LD    = 3'b110;
    localparam logic [2:0] OP_ST    = 3'b111;

    // ALU: returns {valid, carry, result}; valid=0 means fn leaves rd alone.
    function automatic logic [17:0] alu_f(input logic [3:0]  fn,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] sum;
        logic [17:0] r;
        r   = {1'b1, 1'b0, 16'h0000};
        sum = 17'h00000;
        case (fn)
            4'h0: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = {1'b1, sum[16], sum[15:0]};
            end
            4'h1:    r = {1'b1, (a < b), a - b};
            4'h2:    r = {1'b1, 1'b0, a & b};
            4'h3:    r = {1'b1, 1'b0, a | b};
            4'h4:    r = {1'b1, 1'b0, a ^ b};
            4'h5:    r = {1'b1, 1'b0, ~a};
            4'h6:    r = {1'b1, a[15], a[14:0], 1'b0};
            4'h7:    r = {1'b1, a[0], 1'b0, a[15:1]};
            4'h8:    r = {1'b1, 1'b0, a};
            default: r = {1'b0, 1'b0, 16'h0000};
        endcase
        return r;
    endfunction

    // Architectural and control state
    state_t      state_r;
    state_t      state_s;
    logic [15:0] pc_r;
    logic [15:0] gpr_r [0:6];
    logic        flag_z_r;
    logic        flag_n_r;
    logic        flag_c_r;
    logic        hold_r;
    logic [15:0] ea_r;
    logic [2:0]  wb_rd_r;

    // Decode fields (meaningful only in EXEC, where data_in is the instruction)
    logic [2:0]  op_s;
    logic [2:0]  rd_idx_s;
    logic [2:0]  ra_idx_s;
    logic [2:0]  rb_idx_s;
    logic [3:0]  fn_s;
    logic [15:0] off10_s;
    logic [15:0] off7_s;
    logic [15:0] rd_val_s;
    logic [15:0] ra_val_s;
    logic [15:0] rb_val_s;
    logic [15:0] sp_s;
    logic [17:0] alu_s;
    logic [15:0] rel_target_s;
    logic [15:0] ea_calc_s;
    logic        cond_s;

    // Next-state / datapath control
    logic [15:0] addr_s;
    logic        write_s;
    logic [15:0] dout_s;
    logic        wr_en_s;
    logic [2:0]  wr_idx_s;
    logic [15:0] wr_data_s;
    logic        sp_we_s;
    logic [15:0] sp_data_s;
    logic        jmp_we_s;
    logic        flags_we_s;
    logic        flag_z_s;
    logic        flag_n_s;
    logic        flag_c_s;
    logic        hold_set_s;
    logic [15:0] ea_s;
    logic [2:0]  wb_rd_s;

    assign op_s         = data_in[15:13];
    assign rd_idx_s     = data_in[12:10];
    assign ra_idx_s     = data_in[9:7];
    assign rb_idx_s     = data_in[6:4];
    assign fn_s         = data_in[3:0];
    assign off10_s      = {{6{data_in[9]}}, data_in[9:0]};
    assign off7_s       = {{9{data_in[6]}}, data_in[6:0]};
    assign sp_s         = gpr_r[6];
    assign rel_target_s = pc_r + off10_s;
    assign ea_calc_s    = ra_val_s + off7_s;
    assign alu_s        = alu_f(fn_s, ra_val_s, rb_val_s);

    // Register-file read ports; index 7 reads the PC
    always_comb begin
        rd_val_s = 16'h0000;
        ra_val_s = 16'h0000;
        rb_val_s = 16'h0000;
        if (rd_idx_s == 3'd7) rd_val_s = pc_r;
        else                  rd_val_s = gpr_r[rd_idx_s];
        if (ra_idx_s == 3'd7) ra_val_s = pc_r;
        else                  ra_val_s = gpr_r[ra_idx_s];
        if (rb_idx_s == 3'd7) rb_val_s = pc_r;
        else                  rb_val_s = gpr_r[rb_idx_s];
    end

    // Branch condition evaluation from the current flags
    always_comb begin
        cond_s = 1'b0;
        case (data_in[12:10])
            3'd0:    cond_s = 1'b1;
            3'd1:    cond_s = flag_z_r;
            3'd2:    cond_s = ~flag_z_r;
            3'd3:    cond_s = flag_c_r;
            3'd4:    cond_s = ~flag_c_r;
            3'd5:    cond_s = flag_n_r;
            3'd6:    cond_s = ~flag_n_r;
            default: cond_s = 1'b0;
        endcase
    end

    // Next-state, memory-port and register-update decode
    always_comb begin
        state_s    = state_r;
        addr_s     = pc_r;
        write_s    = 1'b0;
        dout_s     = 16'h0000;
        wr_en_s    = 1'b0;
        wr_idx_s   = rd_idx_s;
        wr_data_s  = 16'h0000;
        sp_we_s    = 1'b0;
        sp_data_s  = sp_s;
        jmp_we_s   = 1'b0;
        flags_we_s = 1'b0;
        flag_z_s   = flag_z_r;
        flag_n_s   = flag_n_r;
        flag_c_s   = flag_c_r;
        hold_set_s = 1'b0;
        ea_s       = ea_r;
        wb_rd_s    = wb_rd_r;
        case (state_r)
            ST_FETCH: begin
                addr_s  = pc_r;
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                // Non-memory instructions keep showing their own address
                addr_s  = pc_r - 16'd1;
                state_s = ST_FETCH;
                case (op_s)
                    OP_ALU: begin
                        if (alu_s[17]) begin
                            wr_en_s    = 1'b1;
                            wr_data_s  = alu_s[15:0];
                            flags_we_s = 1'b1;
                            flag_z_s   = (alu_s[15:0] == 16'h0000);
                            flag_n_s   = alu_s[15];
                            flag_c_s   = alu_s[16];
                        end else begin
                            wr_en_s = 1'b0;
                        end
                    end
                    OP_STACK: begin
                        if (fn_s == 4'hC) begin
                            addr_s    = sp_s;
                            write_s   = 1'b1;
                            dout_s    = rd_val_s;
                            sp_we_s   = 1'b1;
                            sp_data_s = sp_s - 16'd1;
                        end else if (fn_s == 4'hD) begin
                            addr_s    = sp_s + 16'd1;
                            ea_s      = sp_s + 16'd1;
                            sp_we_s   = 1'b1;
                            sp_data_s = sp_s + 16'd1;
                            wb_rd_s   = rd_idx_s;
                            state_s   = ST_WB;
                        end else begin
                            sp_we_s = 1'b0;
                        end
                    end
                    OP_BR: begin
                        if (cond_s) begin
                            jmp_we_s   = 1'b1;
                            hold_set_s = (rel_target_s == pc_r - 16'd1);
                        end else begin
                            jmp_we_s = 1'b0;
                        end
                    end
                    OP_LDI: begin
                        wr_en_s = 1'b1;
                        if (data_in[9]) wr_data_s = {8'h00, data_in[7:0]};
                        else            wr_data_s = {data_in[7:0], rd_val_s[7:0]};
                    end
                    OP_JMP: begin
                        jmp_we_s   = 1'b1;
                        hold_set_s = (rel_target_s == pc_r - 16'd1);
                    end
                    OP_CALL: begin
                        addr_s    = sp_s;
                        write_s   = 1'b1;
                        dout_s    = pc_r;
                        sp_we_s   = 1'b1;
                        sp_data_s = sp_s - 16'd1;
                        jmp_we_s  = 1'b1;
                    end
                    OP_LD: begin
                        addr_s  = ea_calc_s;
                        ea_s    = ea_calc_s;
                        wb_rd_s = rd_idx_s;
                        state_s = ST_WB;
                    end
                    OP_ST: begin
                        addr_s  = ea_calc_s;
                        write_s = 1'b1;
                        dout_s  = rd_val_s;
                    end
                    default: state_s = ST_FETCH;
                endcase
            end
            ST_WB: begin
                addr_s    = ea_r;
                wr_en_s   = 1'b1;
                wr_idx_s  = wb_rd_r;
                wr_data_s = data_in;
                state_s   = ST_FETCH;
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // State, PC, register file, flags and halt flag update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_FETCH;
            pc_r     <= RESET_PC;
            for (int i = 0; i < 7; i++) gpr_r[i] <= 16'h0000;
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_c_r <= 1'b0;
            hold_r   <= 1'b0;
            ea_r     <= 16'h0000;
            wb_rd_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            ea_r    <= ea_s;
            wb_rd_r <= wb_rd_s;
            if (state_r == ST_FETCH) begin
                pc_r <= pc_r + 16'd1;
            end else if (jmp_we_s) begin
                pc_r <= rel_target_s;
            end else if (wr_en_s && (wr_idx_s == 3'd7)) begin
                pc_r <= wr_data_s;
            end
            if (sp_we_s) begin
                gpr_r[6] <= sp_data_s;
            end
            if (wr_en_s && (wr_idx_s != 3'd7)) begin
                gpr_r[wr_idx_s] <= wr_data_s;
            end
            if (flags_we_s) begin
                flag_z_r <= flag_z_s;
                flag_n_r <= flag_n_s;
                flag_c_r <= flag_c_s;
            end
            if (hold_set_s) begin
                hold_r <= 1'b1;
            end
        end
    end

    // Reset wins over any in-flight store: no strobe on a reset edge
    assign write    = write_s & ~reset;
    assign data_out = write ? dout_s : 16'h0000;
    assign address  = addr_s;
    assign busy     = (state_r != ST_FETCH);
    assign hold     = hold_r;

endmodule

// File: tb/tb_k16_cpu.sv
// Directed testbench for k16_cpu with a behavioural synchronous RAM.
module tb_k16_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        busy;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        write;

    logic [15:0] mem    [0:255];
    logic [15:0] prog   [0:255];
    int          wr_cnt [0:255];
    logic        load_req = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    k16_cpu #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .busy     (busy),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .write    (write)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data one cycle later, write on the strobe edge
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]    <= prog[i];
                wr_cnt[i] <= 0;
            end
        end else if (write) begin
            mem[address[7:0]]    <= data_out;
            wr_cnt[address[7:0]] <= wr_cnt[address[7:0]] + 1;
        end
        data_in <= mem[address[7:0]];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    // Hold reset while the RAM is loaded, release on a falling edge
    task automatic boot();
        @(negedge clk);
        reset    = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_req = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic wait_fetch(input string tag, input logic [15:0] a, input int budget);
        int n;
        n = 0;
        while (!(busy === 1'b0 && address === a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {15'd0, (n < budget)}, 16'd1);
    endtask

    task automatic wait_hold(input string tag, input int budget);
        int n;
        n = 0;
        while (hold !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {15'd0, (n < budget)}, 16'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;

        // ---- Load / store program ----
        clear_prog();
        prog[0] = 16'hC383; prog[1] = 16'h000C; prog[2] = 16'hE381;
        prog[3] = 16'h9FFF; prog[4] = 16'h000A;
        boot();
        chk("rst_address", address, 16'h0000);
        chk("rst_write", {15'd0, write}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_hold", {15'd0, hold}, 16'd0);
        chk("rst_data_out", data_out, 16'h0000);
        @(negedge clk);
        chk("exec_busy", {15'd0, busy}, 16'd1);
        wait_hold("ls_hold", 60);
        chk("ls_r0", dut.gpr_r[0], 16'h000A);
        chk("ls_mem4", mem[4], 16'h000A);
        chk("ls_wr4_count", 16'(wr_cnt[4]), 16'd1);
        wait_fetch("ls_loop_fetch", 16'h0003, 6);
        @(negedge clk);
        chk("ls_loop_exec_addr", address, 16'h0003);
        @(negedge clk);
        chk("ls_loop_fetch_addr", address, 16'h0003);
        chk("ls_loop_fetch_busy", {15'd0, busy}, 16'd0);

        // ---- Call / return program ----
        clear_prog();
        prog[0] = 16'h7A10; prog[1] = 16'hC386; prog[2] = 16'hC786;
        prog[3] = 16'hBC02; prog[4] = 16'hEB85; prog[5] = 16'h9FFF;
        prog[6] = 16'h0810; prog[7] = 16'h3C0D; prog[8] = 16'h000A;
        prog[9] = 16'h000D;
        boot();
        wait_fetch("cr_reach_6", 16'h0006, 40);
        chk("cr_r6_after_call", dut.gpr_r[6], 16'h000F);
        chk("cr_mem16", mem[16], 16'h0004);
        chk("cr_r0", dut.gpr_r[0], 16'h000A);
        chk("cr_r1", dut.gpr_r[1], 16'h000D);
        wait_fetch("cr_ret_to_4", 16'h0004, 20);
        chk("cr_r6_after_ret", dut.gpr_r[6], 16'h0010);
        chk("cr_r2_add", dut.gpr_r[2], 16'h0017);
        wait_hold("cr_hold", 30);
        chk("cr_mem10", mem[10], 16'h0017);
        chk("cr_wr10_count", 16'(wr_cnt[10]), 16'd1);
        chk("cr_wr16_count", 16'(wr_cnt[16]), 16'd1);

        // ---- ALU flags, branches, LDI, SHR ----
        clear_prog();
        prog[0]  = 16'h62FF; prog[1]  = 16'h60FF; prog[2]  = 16'h6601;
        prog[3]  = 16'h0810; prog[4]  = 16'h4401; prog[5]  = 16'h9FFF;
        prog[6]  = 16'h4801; prog[7]  = 16'h6E34; prog[8]  = 16'h6C12;
        prog[9]  = 16'h1187; prog[10] = 16'hF395; prog[11] = 16'h9FFF;
        boot();
        wait_fetch("alu_reach_4", 16'h0004, 20);
        chk("alu_r0", dut.gpr_r[0], 16'hFFFF);
        chk("alu_r2", dut.gpr_r[2], 16'h0000);
        chk("alu_z", {15'd0, dut.flag_z_r}, 16'd1);
        chk("alu_c", {15'd0, dut.flag_c_r}, 16'd1);
        chk("alu_n", {15'd0, dut.flag_n_r}, 16'd0);
        wait_hold("alu_hold", 40);
        wait_fetch("alu_halt_at_11", 16'h000B, 6);
        chk("ldi_r3", dut.gpr_r[3], 16'h1234);
        chk("shr_r4", dut.gpr_r[4], 16'h091A);
        chk("shr_c", {15'd0, dut.flag_c_r}, 16'd0);
        chk("shr_store", mem[32], 16'h091A);

        // ---- Reset in the middle of LD and of ST ----
        clear_prog();
        prog[0] = 16'h6255; prog[1] = 16'hC382; prog[2] = 16'hE382;
        prog[3] = 16'h9FFF; prog[4] = 16'hBEEF;
        boot();
        wait_fetch("rl_reach_1", 16'h0001, 10);
        @(negedge clk);
        @(negedge clk);
        chk("rl_wb_busy", {15'd0, busy}, 16'd1);
        chk("rl_wb_address", address, 16'h0004);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rl_r0", dut.gpr_r[0], 16'h0000);
        chk("rl_pc_address", address, 16'h0000);
        chk("rl_busy", {15'd0, busy}, 16'd0);
        chk("rl_write", {15'd0, write}, 16'd0);
        wait_fetch("rs_reach_2", 16'h0002, 20);
        chk("rs_r0_loaded", dut.gpr_r[0], 16'hBEEF);
        @(negedge clk);
        chk("rs_exec_write", {15'd0, write}, 16'd1);
        chk("rs_exec_address", address, 16'h0005);
        chk("rs_exec_data", data_out, 16'hBEEF);
        reset = 1'b1;
        #1;
        chk("rs_write_gated", {15'd0, write}, 16'd0);
        chk("rs_data_gated", data_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        chk("rs_no_store", 16'(wr_cnt[5]), 16'd0);
        chk("rs_mem5", mem[5], 16'h0000);
        chk("rs_pc_address", address, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
